fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of decode. Owns the PC and drives the BIOS ROM address. It delivers one registered instruction plus its PC to decode through a valid/stall handshake. Boots from BIOS; after the BIOS executes halt, a resume pulse switches fetch to main instruction memory, which has variable latency and a req/ack interface.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage constants, opcode field and FSM encoding
package fetch_unit_pkg;
  localparam int DEF_PC_WIDTH = 26;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_BIOS_SIZE = 65;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam logic [5:0] OPC_HALT = 6'b111111;
  typedef enum logic [1:0] {BIOS, MEM_REQ, HALT} state_t;
  function automatic logic is_halt(input logic [5:0] opc);
    return opc == OPC_HALT;
  endfunction
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage with BIOS boot, halt/resume, req/ack main memory and redirect flush
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int BIOS_SIZE = DEF_BIOS_SIZE
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    bios_pc,
  input  logic [INSTR_WIDTH-1:0] bios_instr,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   resume,
  output logic [INSTR_WIDTH-1:0] instrucao,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  output logic                   in_bios,
  output logic                   halted,
  output logic                   bios_fault
);
  localparam logic [PC_WIDTH-1:0] BIOS_END = PC_WIDTH'(BIOS_SIZE);
  state_t st, st_n;
  logic [PC_WIDTH-1:0] pc, pc_n, addr_n, ld_pc;
  logic [INSTR_WIDTH-1:0] ld_data;
  logic slot, done, bios_ld, mem_ld, ld, req_n, in_bios_n, fault_n, discard, discard_n;
  assign slot = (~instr_valid | ~stall) & ~redirect;
  assign done = imem_req & imem_ack;
  assign bios_ld = (st == BIOS) & slot & (pc < BIOS_END);
  assign mem_ld = (st == MEM_REQ) & done & ~discard & slot;
  assign ld = bios_ld | mem_ld;
  assign ld_data = (st == BIOS) ? bios_instr : imem_rdata;
  assign ld_pc = (st == BIOS) ? pc : imem_addr;
  assign bios_pc = pc;
  assign halted = st == HALT;
  always_comb begin
    st_n = st;
    pc_n = pc;
    req_n = imem_req;
    addr_n = imem_addr;
    in_bios_n = in_bios;
    fault_n = bios_fault;
    discard_n = discard;
    if (ld) begin
      pc_n = pc + PC_WIDTH'(1);
      st_n = is_halt(ld_data[OPC_HI:OPC_LO]) ? HALT : st;
    end
    if (done) begin
      req_n = 1'b0;
      discard_n = 1'b0;
    end
    if (redirect) begin
      pc_n = redirect_pc;
      discard_n = imem_req & ~imem_ack;
      st_n = (st == HALT) ? (in_bios ? BIOS : MEM_REQ) : st;
    end else if (st == HALT && resume) begin
      st_n = MEM_REQ;
      in_bios_n = 1'b0;
      pc_n = in_bios ? '0 : pc;
    end else if (st == BIOS && slot && pc >= BIOS_END) begin
      fault_n = 1'b1;
      st_n = HALT;
    end else if (st == MEM_REQ && !imem_req && slot) begin
      req_n = 1'b1;
      addr_n = pc;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= BIOS;
      pc <= '0;
      in_bios <= 1'b1;
      instrucao <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
      imem_req <= 1'b0;
      imem_addr <= '0;
      bios_fault <= 1'b0;
      discard <= 1'b0;
    end else begin
      st <= st_n;
      pc <= pc_n;
      in_bios <= in_bios_n;
      if (ld) begin
        instrucao <= ld_data;
        instr_pc <= ld_pc;
      end
      instr_valid <= ld | (instr_valid & stall & ~redirect);
      imem_req <= req_n;
      imem_addr <= addr_n;
      bios_fault <= fault_n;
      discard <= discard_n;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table, directed and randomized self-checking bench for fetch_unit
module tb_fetch_unit;
  localparam int PW = 26;
  localparam int IW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic redirect = 1'b0;
  logic resume = 1'b0;
  logic imem_ack = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic [IW-1:0] imem_rdata = '0;
  logic [PW-1:0] bios_pc, imem_addr, instr_pc;
  logic [IW-1:0] bios_instr, instrucao;
  logic imem_req, instr_valid, in_bios, halted, bios_fault;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rom_halt = 1'b1;
  bit mem_rand = 1'b0;
  bit mem_busy = 1'b0;
  int mem_lat = 2;
  int mem_cnt = 0;
  logic [PW-1:0] mem_a = '0;
  typedef struct {
    bit stall;
    bit valid;
    logic [PW-1:0] ipc;
    logic [PW-1:0] bpc;
  } vec_t;
  vec_t vt [12];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fetch_unit dut (
    .clock(clk), .reset(reset), .bios_pc(bios_pc), .bios_instr(bios_instr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
    .instrucao(instrucao), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .in_bios(in_bios), .halted(halted), .bios_fault(bios_fault)
  );
  function automatic logic [IW-1:0] rom_word(input logic [PW-1:0] a, input bit h);
    return (h && a == PW'(58)) ? 32'hFC000000 : {6'h02, a * PW'(7) + PW'(3)};
  endfunction
  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {6'h05, a ^ PW'(26'h2aaaaaa)};
  endfunction
  assign bios_instr = rom_word(bios_pc, rom_halt);
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic wait_valid(input string name);
    int c = 0;
    while (!instr_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk(name, instr_valid, 1);
  endtask
  task automatic wait_req(input string name, input bit any_addr, input logic [PW-1:0] a);
    int c = 0;
    while (!(imem_req && (any_addr || imem_addr == a)) && c < 80) begin
      @(negedge clk);
      c++;
    end
    chk(name, imem_req, 1);
  endtask
  initial forever begin
    @(negedge clk);
    if (imem_ack || reset) begin
      imem_ack = 1'b0;
      mem_busy = 1'b0;
    end else if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_a = imem_addr;
        mem_cnt = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      end else chk("imem_addr_stable", imem_addr, mem_a);
      if (mem_cnt == 0) begin
        imem_ack = 1'b1;
        imem_rdata = mem_word(mem_a);
      end else mem_cnt--;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  initial begin
    int last;
    bit synced;
    int ndel;
    logic [PW-1:0] exp_pc;
    vt = '{
      '{1'b0, 1'b0, 26'd0, 26'd0}, '{1'b0, 1'b1, 26'd0, 26'd1},
      '{1'b0, 1'b1, 26'd1, 26'd2}, '{1'b0, 1'b1, 26'd2, 26'd3},
      '{1'b0, 1'b1, 26'd3, 26'd4}, '{1'b0, 1'b1, 26'd4, 26'd5},
      '{1'b1, 1'b1, 26'd5, 26'd6}, '{1'b1, 1'b1, 26'd5, 26'd6},
      '{1'b1, 1'b1, 26'd5, 26'd6}, '{1'b0, 1'b1, 26'd5, 26'd6},
      '{1'b0, 1'b1, 26'd6, 26'd7}, '{1'b0, 1'b1, 26'd7, 26'd8}
    };
    repeat (3) @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_in_bios", in_bios, 1);
    chk("rst_halted", halted, 0);
    chk("rst_fault", bios_fault, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_instr", instrucao, 0);
    reset = 1'b0;
    foreach (vt[i]) begin
      chk("boot_valid", instr_valid, vt[i].valid);
      chk("boot_instr_pc", instr_pc, vt[i].ipc);
      chk("boot_bios_pc", bios_pc, vt[i].bpc);
      if (vt[i].valid) chk("boot_instr", instrucao, rom_word(vt[i].ipc, 1'b1));
      stall = vt[i].stall;
      @(negedge clk);
    end
    for (int c = 0; c < 80 && !(instr_valid && instr_pc == PW'(58)); c++) @(negedge clk);
    chk("halt_instr_pc", instr_pc, 58);
    chk("halt_instr", instrucao, 32'hFC000000);
    chk("halted_after_load", halted, 1);
    chk("halt_bios_pc", bios_pc, 59);
    stall = 1'b1;
    @(negedge clk);
    chk("halt_held_valid", instr_valid, 1);
    stall = 1'b0;
    @(negedge clk);
    chk("halt_consumed", instr_valid, 0);
    repeat (3) @(negedge clk);
    chk("halt_no_fetch_pc", bios_pc, 59);
    chk("halt_no_fetch_valid", instr_valid, 0);
    chk("halt_stays", halted, 1);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_in_bios", in_bios, 0);
    chk("resume_halted", halted, 0);
    wait_req("resume_req", 1'b1, '0);
    chk("resume_addr", imem_addr, 0);
    last = -100;
    for (int k = 0; k < 3; k++) begin
      wait_valid("mem_deliver");
      chk("mem_instr_pc", instr_pc, PW'(k));
      chk("mem_instr", instrucao, mem_word(PW'(k)));
      if (k > 0) chk("mem_gap_ge2", cyc - last >= 2, 1);
      last = cyc;
      @(negedge clk);
    end
    for (int c = 0; c < 60 && !(instr_valid && instr_pc == PW'(6)); c++) @(negedge clk);
    chk("reach_pc6", instr_pc, 6);
    wait_req("req_at_7", 1'b0, PW'(7));
    chk("req_addr_7", imem_addr, 7);
    redirect = 1'b1;
    redirect_pc = PW'(26'h100);
    @(negedge clk);
    redirect = 1'b0;
    chk("discard_req_held", imem_req, 1);
    chk("discard_addr_held", imem_addr, 7);
    wait_valid("redir_deliver");
    chk("redir_instr_pc", instr_pc, 26'h100);
    chk("redir_instr", instrucao, mem_word(PW'(26'h100)));
    @(negedge clk);
    mem_rand = 1'b1;
    synced = 1'b0;
    ndel = 0;
    exp_pc = '0;
    for (int c = 0; c < 1500; c++) begin
      stall = $urandom_range(0, 9) < 3;
      redirect = ($urandom_range(0, 49) == 0) || !synced;
      redirect_pc = ($urandom_range(0, 3) == 0) ? PW'(26'h3fffffd) : PW'($urandom);
      if (synced && instr_valid && !stall) begin
        chk("rand_instr_pc", instr_pc, exp_pc);
        chk("rand_instr", instrucao, mem_word(instr_pc));
        exp_pc = exp_pc + PW'(1);
        ndel++;
      end
      if (redirect) begin
        exp_pc = redirect_pc;
        synced = 1'b1;
      end
      @(negedge clk);
    end
    chk("rand_progress", ndel > 100, 1);
    redirect = 1'b0;
    stall = 1'b0;
    mem_rand = 1'b0;
    reset = 1'b1;
    rom_halt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      chk("fault_seq_pc", instr_pc, PW'(k - 1));
      if (k == 65) begin
        chk("fault_last_valid", instr_valid, 1);
        chk("fault_not_yet", bios_fault, 0);
      end
    end
    @(negedge clk);
    chk("fault_set", bios_fault, 1);
    chk("fault_halted", halted, 1);
    chk("fault_no_load", instr_valid, 0);
    chk("fault_bios_pc", bios_pc, 65);
    mem_lat = 6;
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    wait_req("post_fault_req", 1'b0, PW'(1));
    chk("post_fault_addr", imem_addr, 1);
    chk("fault_sticky", bios_fault, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", imem_req, 0);
    chk("rst_mid_addr", imem_addr, 0);
    chk("rst_mid_valid", instr_valid, 0);
    chk("rst_mid_instr", instrucao, 0);
    chk("rst_mid_instr_pc", instr_pc, 0);
    chk("rst_mid_bios_pc", bios_pc, 0);
    chk("rst_mid_in_bios", in_bios, 1);
    chk("rst_mid_fault", bios_fault, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
